sig_round_pipe: RTL and testbench



---
 rtl/sig_round_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_sig_round_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_round_pipe.sv
// Significand normalise-and-round pipeline: 57-bit unrounded fq in, rounded 53-bit significand out.
// Define SIGRND_SKID_EN to add a one-entry input skid buffer with a registered in_ready.
module sig_round_pipe #(
   parameter int EW = 13
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [56:0]          in_fq,
   input  logic signed [EW-1:0] in_exp,
   input  logic                 in_sign,
   input  logic                 in_db,
   input  logic [1:0]           in_rm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [52:0]          out_sig,
   output logic signed [EW-1:0] out_exp,
   output logic                 out_sign,
   output logic                 out_db,
   output logic                 out_inexact
);

   localparam logic [EW-1:0] EXP_ONE = EW'(1);

   typedef struct packed {
      logic [52:0] sig;
      logic        carry;
      logic        inexact;
   } rnd_t;

   // Bring the leading one to bit 55; a value below 2^54 collapses to zero.
   function automatic logic [55:0] norm_sig(input logic [56:0] fq);
      if (fq[56])      return {fq[56:2], fq[1] | fq[0]};
      else if (fq[55]) return fq[55:0];
      else if (fq[54]) return {fq[54:0], 1'b0};
      else             return '0;
   endfunction

   function automatic logic signed [EW-1:0] norm_exp(input logic [2:0] top,
                                                     input logic signed [EW-1:0] e);
      if (top[2])      return e + EXP_ONE;
      else if (top[1]) return e;
      else if (top[0]) return e - EXP_ONE;
      else             return e;
   endfunction

   function automatic rnd_t round_fn(input logic [55:0] n, input logic db,
                                     input logic [1:0] rm, input logic sign);
      rnd_t        r;
      logic        l, g, s, inc;
      logic [53:0] kd;
      logic [24:0] ks;
      if (db) begin
         l = n[3];  g = n[2];  s = n[1] | n[0];
      end else begin
         l = n[32]; g = n[31]; s = |n[30:0];
      end
      case (rm)
         2'b00:   inc = g & (s | l);
         2'b01:   inc = 1'b0;
         2'b10:   inc = !sign & (g | s);
         default: inc = sign & (g | s);
      endcase
      kd = {1'b0, n[55:3]} + {53'b0, inc};
      ks = {1'b0, n[55:32]} + {24'b0, inc};
      if (db) begin
         r.carry = kd[53];
         r.sig   = kd[53] ? {1'b1, 52'b0} : kd[52:0];
      end else begin
         r.carry = ks[24];
         r.sig   = {(ks[24] ? {1'b1, 23'b0} : ks[23:0]), 29'b0};
      end
      r.inexact = g | s;
      return r;
   endfunction

   logic                 s2_adv, s1_load, acc, src_vld;
   logic [56:0]          src_fq;
   logic signed [EW-1:0] src_exp;
   logic                 src_sign, src_db;
   logic [1:0]           src_rm;

   logic                 vld_p1_q, vld_p1_d;
   logic [55:0]          n_p1_q, n_p1_d;
   logic signed [EW-1:0] exp_p1_q, exp_p1_d;
   logic                 sign_p1_q, sign_p1_d, db_p1_q, db_p1_d;
   logic [1:0]           rm_p1_q, rm_p1_d;

   logic                 vld_p2_q, vld_p2_d;
   logic [52:0]          sig_p2_q, sig_p2_d;
   logic signed [EW-1:0] exp_p2_q, exp_p2_d;
   logic                 sign_p2_q, sign_p2_d, db_p2_q, db_p2_d, inx_p2_q, inx_p2_d;
   rnd_t                 rnd;

   assign s2_adv  = !vld_p2_q || out_ready;
   assign s1_load = !vld_p1_q || s2_adv;

`ifdef SIGRND_SKID_EN
   logic                 rdy_q, sk_vld_q, sk_vld_d;
   logic [56:0]          sk_fq_q, sk_fq_d;
   logic signed [EW-1:0] sk_exp_q, sk_exp_d;
   logic                 sk_sign_q, sk_sign_d, sk_db_q, sk_db_d;
   logic [1:0]           sk_rm_q, sk_rm_d;

   assign in_ready = rdy_q;

   // The skid entry always feeds stage 1 first so beat order is preserved.
   always_comb begin
      acc       = in_valid && rdy_q;
      src_vld   = sk_vld_q || acc;
      src_fq    = sk_vld_q ? sk_fq_q   : in_fq;
      src_exp   = sk_vld_q ? sk_exp_q  : in_exp;
      src_sign  = sk_vld_q ? sk_sign_q : in_sign;
      src_db    = sk_vld_q ? sk_db_q   : in_db;
      src_rm    = sk_vld_q ? sk_rm_q   : in_rm;
      sk_vld_d  = sk_vld_q ? !s1_load : (acc && !s1_load);
      sk_fq_d   = sk_fq_q;
      sk_exp_d  = sk_exp_q;
      sk_sign_d = sk_sign_q;
      sk_db_d   = sk_db_q;
      sk_rm_d   = sk_rm_q;
      if (!sk_vld_q && acc && !s1_load) begin
         sk_fq_d   = in_fq;
         sk_exp_d  = in_exp;
         sk_sign_d = in_sign;
         sk_db_d   = in_db;
         sk_rm_d   = in_rm;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q     <= 1'b1;
         sk_vld_q  <= 1'b0;
         sk_fq_q   <= '0;
         sk_exp_q  <= '0;
         sk_sign_q <= 1'b0;
         sk_db_q   <= 1'b0;
         sk_rm_q   <= '0;
      end else begin
         rdy_q     <= !sk_vld_d;
         sk_vld_q  <= sk_vld_d;
         sk_fq_q   <= sk_fq_d;
         sk_exp_q  <= sk_exp_d;
         sk_sign_q <= sk_sign_d;
         sk_db_q   <= sk_db_d;
         sk_rm_q   <= sk_rm_d;
      end
   end
`else
   assign in_ready = s1_load;

   always_comb begin
      acc      = in_valid && s1_load;
      src_vld  = acc;
      src_fq   = in_fq;
      src_exp  = in_exp;
      src_sign = in_sign;
      src_db   = in_db;
      src_rm   = in_rm;
   end
`endif

   // Stage 1 boundary: normalise
   always_comb begin
      vld_p1_d  = s1_load ? src_vld : vld_p1_q;
      n_p1_d    = n_p1_q;
      exp_p1_d  = exp_p1_q;
      sign_p1_d = sign_p1_q;
      db_p1_d   = db_p1_q;
      rm_p1_d   = rm_p1_q;
      if (s1_load && src_vld) begin
         n_p1_d    = norm_sig(src_fq);
         exp_p1_d  = norm_exp(src_fq[56:54], src_exp);
         sign_p1_d = src_sign;
         db_p1_d   = src_db;
         rm_p1_d   = src_rm;
      end
   end

   // Stage 2 boundary: round; a zero significand rounds to zero with no inexact
   always_comb begin
      rnd       = round_fn(n_p1_q, db_p1_q, rm_p1_q, sign_p1_q);
      vld_p2_d  = s2_adv ? vld_p1_q : vld_p2_q;
      sig_p2_d  = sig_p2_q;
      exp_p2_d  = exp_p2_q;
      sign_p2_d = sign_p2_q;
      db_p2_d   = db_p2_q;
      inx_p2_d  = inx_p2_q;
      if (s2_adv && vld_p1_q) begin
         sig_p2_d  = rnd.sig;
         exp_p2_d  = exp_p1_q + (rnd.carry ? EXP_ONE : '0);
         sign_p2_d = sign_p1_q;
         db_p2_d   = db_p1_q;
         inx_p2_d  = rnd.inexact;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q  <= 1'b0;
         n_p1_q    <= '0;
         exp_p1_q  <= '0;
         sign_p1_q <= 1'b0;
         db_p1_q   <= 1'b0;
         rm_p1_q   <= '0;
         vld_p2_q  <= 1'b0;
         sig_p2_q  <= '0;
         exp_p2_q  <= '0;
         sign_p2_q <= 1'b0;
         db_p2_q   <= 1'b0;
         inx_p2_q  <= 1'b0;
      end else begin
         vld_p1_q  <= vld_p1_d;
         n_p1_q    <= n_p1_d;
         exp_p1_q  <= exp_p1_d;
         sign_p1_q <= sign_p1_d;
         db_p1_q   <= db_p1_d;
         rm_p1_q   <= rm_p1_d;
         vld_p2_q  <= vld_p2_d;
         sig_p2_q  <= sig_p2_d;
         exp_p2_q  <= exp_p2_d;
         sign_p2_q <= sign_p2_d;
         db_p2_q   <= db_p2_d;
         inx_p2_q  <= inx_p2_d;
      end
   end

   assign out_valid   = vld_p2_q;
   assign out_sig     = sig_p2_q;
   assign out_exp     = exp_p2_q;
   assign out_sign    = sign_p2_q;
   assign out_db      = db_p2_q;
   assign out_inexact = inx_p2_q;

endmodule

// File: tb/tb_sig_round_pipe.sv
// Scoreboard bench for sig_round_pipe: directed rounding cases, back-pressure, reset and random traffic.
module tb_sig_round_pipe;

   localparam int EW = 13;
`ifdef SIGRND_SKID_EN
   localparam int CAP = 3;
`else
   localparam int CAP = 2;
`endif
   localparam logic [52:0] SIG_ONE = 53'd1 << 52;
   localparam logic [56:0] FQ_ONE  = 57'd1 << 55;

   typedef struct packed {
      logic [52:0]   sig;
      logic [EW-1:0] ex;
      logic          sign;
      logic          db;
      logic          inx;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [56:0]   in_fq = '0;
   logic [EW-1:0] in_exp = '0;
   logic          in_sign = 1'b0;
   logic          in_db = 1'b0;
   logic [1:0]    in_rm = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [52:0]   out_sig;
   logic [EW-1:0] out_exp;
   logic          out_sign, out_db, out_inexact;

   int   n_chk = 0;
   int   n_pass = 0;
   int   mode = 0;
   exp_t sb[$];

   sig_round_pipe #(.EW(EW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_fq(in_fq), .in_exp(in_exp),
      .in_sign(in_sign), .in_db(in_db), .in_rm(in_rm),
      .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig), .out_exp(out_exp),
      .out_sign(out_sign), .out_db(out_db), .out_inexact(out_inexact)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      case (mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom % 4) != 0;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
   endtask

   function automatic exp_t mk(input logic [52:0] s, input logic [EW-1:0] e,
                               input logic sg, input logic d, input logic x);
      exp_t r;
      r.sig = s; r.ex = e; r.sign = sg; r.db = d; r.inx = x;
      return r;
   endfunction

   // Reference: keep the top p bits of the value, round the discarded remainder against one half.
   function automatic exp_t ref_model(input logic [56:0] fq, input logic [EW-1:0] e,
                                      input logic sg, input logic d, input logic [1:0] rm);
      exp_t        r;
      int          lead, p, sh;
      logic [63:0] v, kept, rem, half;
      logic        up;
      v = {7'b0, fq};
      lead = -1;
      for (int b = 56; b >= 54; b--) if (lead < 0 && v[b]) lead = b;
      r.sign = sg;
      r.db   = d;
      if (lead < 0) begin
         r.sig = '0; r.ex = e; r.inx = 1'b0;
         return r;
      end
      p    = d ? 53 : 24;
      sh   = lead - (p - 1);
      kept = v >> sh;
      rem  = v - (kept << sh);
      half = 64'd1 << (sh - 1);
      case (rm)
         2'd0:    up = (rem > half) || (rem == half && kept[0]);
         2'd1:    up = 1'b0;
         2'd2:    up = !sg && rem != 0;
         default: up = sg && rem != 0;
      endcase
      kept = kept + 64'(up);
      r.ex = e + EW'(lead - 55);
      if (kept == (64'd1 << p)) begin
         kept = 64'd1 << (p - 1);
         r.ex = r.ex + EW'(1);
      end
      kept  = kept << (53 - p);
      r.sig = kept[52:0];
      r.inx = rem != 0;
      return r;
   endfunction

   // Monitor: pops on each transfer and checks that a stalled beat holds still.
   logic          stall_q = 1'b0;
   logic [52:0]   h_sig;
   logic [EW-1:0] h_exp;
   logic          h_sign, h_db, h_inx;
   exp_t          got_e;

   always @(negedge clk) begin
      if (rst) stall_q = 1'b0;
      else begin
         if (stall_q) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_sig", 64'(out_sig), 64'(h_sig));
            chk("hold_exp", 64'(out_exp), 64'(h_exp));
            chk("hold_flags", {61'b0, out_sign, out_db, out_inexact}, {61'b0, h_sign, h_db, h_inx});
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_beat: got sig %0h required no beat (t=%0t)", out_sig, $time);
            end else begin
               got_e = sb.pop_front();
               chk("sig", 64'(out_sig), 64'(got_e.sig));
               chk("exp", 64'(out_exp), 64'(got_e.ex));
               chk("sign", 64'(out_sign), 64'(got_e.sign));
               chk("db", 64'(out_db), 64'(got_e.db));
               chk("inexact", 64'(out_inexact), 64'(got_e.inx));
            end
         end
         stall_q = out_valid && !out_ready;
         h_sig = out_sig; h_exp = out_exp; h_sign = out_sign; h_db = out_db; h_inx = out_inexact;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [56:0] fq, input logic [EW-1:0] e, input logic sg,
                       input logic d, input logic [1:0] rm, input exp_t ex);
      bit ok;
      ok = 0;
      in_fq = fq; in_exp = e; in_sign = sg; in_db = d; in_rm = rm; in_valid = 1'b1;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (!ok) begin
         n_chk++;
         $display("FAIL send_timeout: got in_ready 0 required 1 within 500 cycles");
      end else sb.push_back(ex);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_rand(input logic [56:0] fq, input logic [EW-1:0] e, input logic sg,
                            input logic d, input logic [1:0] rm);
      send(fq, e, sg, d, rm, ref_model(fq, e, sg, d, rm));
   endtask

   task automatic drain();
      for (int k = 0; k < 400; k++) begin
         if (sb.size() == 0) break;
         @(posedge clk); #1;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   function automatic logic [56:0] rand_fq(input logic d);
      logic [56:0] f;
      int          cls;
      f   = 57'({$urandom, $urandom});
      cls = $urandom % 9;
      case (cls)
         0, 1:    f[56] = 1'b1;
         2, 3, 4: f[56:55] = 2'b01;
         5:       f[56:54] = 3'b001;
         6:       f[56:54] = 3'b000;
         7: begin
            f[56:55] = 2'b01;
            if (d) f[2:0] = 3'b100;
            else   f[31:0] = 32'h8000_0000;
         end
         default: f = {1'b0, {56{1'b1}}};
      endcase
      return f;
   endfunction

   logic [56:0]   bp_fq[4];
   logic [EW-1:0] bp_exp[4];
   logic          bp_sign[4], bp_db[4];
   logic [1:0]    bp_rm[4];
   int            idx;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_sig", 64'(out_sig), 64'd0);
      chk("rst_out_exp", 64'(out_exp), 64'd0);
      chk("rst_out_flags", {61'b0, out_sign, out_db, out_inexact}, 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      mode = 1;
      @(posedge clk); #1;

      send(FQ_ONE, 13'd0, 1'b0, 1'b1, 2'b00, mk(SIG_ONE, 13'd0, 1'b0, 1'b1, 1'b0));
      chk("lat_not_yet", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk("lat_two", 64'(out_valid), 64'd1);

      send((57'd1 << 56) + 57'd1, 13'd5, 1'b0, 1'b1, 2'b00, mk(SIG_ONE, 13'd6, 1'b0, 1'b1, 1'b1));
      send((57'd1 << 56) + 57'd1, 13'd5, 1'b0, 1'b1, 2'b10, mk(SIG_ONE + 53'd1, 13'd6, 1'b0, 1'b1, 1'b1));
      send((57'd1 << 56) + 57'd1, 13'd5, 1'b1, 1'b1, 2'b11, mk(SIG_ONE + 53'd1, 13'd6, 1'b1, 1'b1, 1'b1));
      send((57'd1 << 56) + 57'd1, 13'd5, 1'b1, 1'b1, 2'b10, mk(SIG_ONE, 13'd6, 1'b1, 1'b1, 1'b1));
      send((57'd1 << 56) - 57'd1, 13'd3, 1'b0, 1'b1, 2'b00, mk(SIG_ONE, 13'd4, 1'b0, 1'b1, 1'b1));
      send((57'd1 << 56) - 57'd1, 13'd3, 1'b0, 1'b1, 2'b01, mk({53{1'b1}}, 13'd3, 1'b0, 1'b1, 1'b1));
      send(FQ_ONE + 57'd4, 13'd0, 1'b0, 1'b1, 2'b00, mk(SIG_ONE, 13'd0, 1'b0, 1'b1, 1'b1));
      send(FQ_ONE + 57'd12, 13'd0, 1'b0, 1'b1, 2'b00, mk(SIG_ONE + 53'd2, 13'd0, 1'b0, 1'b1, 1'b1));
      send(FQ_ONE + (57'd1 << 31), 13'd0, 1'b0, 1'b0, 2'b00, mk(SIG_ONE, 13'd0, 1'b0, 1'b0, 1'b1));
      send(FQ_ONE + (57'd3 << 31), 13'd0, 1'b0, 1'b0, 2'b00, mk(SIG_ONE + (53'd2 << 29), 13'd0, 1'b0, 1'b0, 1'b1));
      send((57'd1 << 56) - 57'd1, 13'd9, 1'b0, 1'b0, 2'b00, mk(SIG_ONE, 13'd10, 1'b0, 1'b0, 1'b1));
      send(57'd1 << 54, 13'd0, 1'b0, 1'b1, 2'b00, mk(SIG_ONE, 13'h1FFF, 1'b0, 1'b1, 1'b0));
      send(57'd0, 13'd7, 1'b1, 1'b1, 2'b10, mk(53'd0, 13'd7, 1'b1, 1'b1, 1'b0));
      send(57'h3F, 13'd7, 1'b0, 1'b1, 2'b00, mk(53'd0, 13'd7, 1'b0, 1'b1, 1'b0));
      send(FQ_ONE, 13'h0FFF, 1'b0, 1'b1, 2'b00, mk(SIG_ONE, 13'h0FFF, 1'b0, 1'b1, 1'b0));
      send(57'd1 << 56, 13'h0FFF, 1'b0, 1'b1, 2'b00, mk(SIG_ONE, 13'h1000, 1'b0, 1'b1, 1'b0));
      drain();

      for (int i = 0; i < 4; i++) begin
         bp_db[i]   = 1'($urandom);
         bp_fq[i]   = rand_fq(bp_db[i]);
         bp_exp[i]  = EW'($urandom);
         bp_sign[i] = 1'($urandom);
         bp_rm[i]   = 2'($urandom);
      end
      mode = 0;
      idx  = 0;
      for (int c = 0; c < 6; c++) begin
         if (idx < 4) begin
            in_fq = bp_fq[idx]; in_exp = bp_exp[idx]; in_sign = bp_sign[idx];
            in_db = bp_db[idx]; in_rm = bp_rm[idx]; in_valid = 1'b1;
         end else in_valid = 1'b0;
         @(negedge clk);
         if (in_valid && in_ready) begin
            sb.push_back(ref_model(bp_fq[idx], bp_exp[idx], bp_sign[idx], bp_db[idx], bp_rm[idx]));
            idx++;
         end
         @(posedge clk); #1;
      end
      chk("bp_accepted", 64'(idx), 64'(CAP));
      mode = 1;
      for (int c = 0; c < 50 && idx < 4; c++) begin
         in_fq = bp_fq[idx]; in_exp = bp_exp[idx]; in_sign = bp_sign[idx];
         in_db = bp_db[idx]; in_rm = bp_rm[idx]; in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(ref_model(bp_fq[idx], bp_exp[idx], bp_sign[idx], bp_db[idx], bp_rm[idx]));
            idx++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_all_in", 64'(idx), 64'd4);
      drain();

      mode = 0;
      send_rand(rand_fq(1'b1), 13'd1, 1'b0, 1'b1, 2'b00);
      send_rand(rand_fq(1'b0), 13'd2, 1'b1, 1'b0, 2'b01);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("rst_async_valid", 64'(out_valid), 64'd0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_release_ready", 64'(in_ready), 64'd1);
      mode = 1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("no_stale", 64'(out_valid), 64'd0);
      end

      mode = 2;
      for (int i = 0; i < 300; i++) begin
         logic d;
         d = 1'($urandom);
         send_rand(rand_fq(d), EW'($urandom), 1'($urandom), d, 2'($urandom));
         repeat ($urandom % 3) begin @(posedge clk); #1; end
      end
      mode = 1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish required finish by 2ms");
      $fatal(1, "timeout");
   end

endmodule
